// File: rtl/elastic_buffer.sv
// Parametrised valid/ready elastic stage: DEPTH-entry circular FIFO with
// registered-only handshake outputs, synchronous flush, occupancy and almost_full.
module elastic_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = DEPTH - 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         count,
  output logic                  almost_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("elastic_buffer: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
      $error("elastic_buffer: AF_THRESH must lie in 1..DEPTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  push;
  logic                  pop;

  // Handshake: a word moves when valid && ready on the same rising edge.
  // in_ready/out_valid decode only registered count and flush, so no
  // combinational path exists from out_ready to in_ready.
  assign in_ready    = (count_q != CW'(DEPTH)) && !flush;
  assign out_valid   = (count_q != '0) && !flush;
  assign out_data    = mem[rd_ptr];
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AF_THRESH));

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_elastic_buffer.sv
// Bench for elastic_buffer: reset/fill/drain vector table, then streaming,
// random, flush and async-reset sequences checked against a queue model.
module tb_elastic_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          almost_full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          f;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          ir;
    logic          ov;
    logic [DW-1:0] od;
    logic [CW-1:0] cnt;
    logic          af;
  } vec_t;

  vec_t vecs[15];

  elastic_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .almost_full(almost_full)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver
  task automatic drive(input logic f, input logic iv, input logic [DW-1:0] d, input logic ordy);
    @(negedge clk);
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  // Scoreboard: compare outputs against the queue model before the edge
  task automatic check_model();
    logic exp_ir;
    logic exp_ov;
    exp_ir = (exp_q.size() != DEPTH) && !flush;
    exp_ov = (exp_q.size() != 0) && !flush;
    check("in_ready", DW'(in_ready), DW'(exp_ir));
    check("out_valid", DW'(out_valid), DW'(exp_ov));
    if (exp_ov && out_valid) check("out_data", out_data, exp_q[0]);
    check("count", DW'(count), DW'(exp_q.size()));
    check("almost_full", DW'(almost_full), DW'(exp_q.size() >= AF));
  endtask

  // Model update at the rising edge using the inputs still being driven
  task automatic update_model();
    logic m_push;
    logic m_pop;
    m_push = in_valid && (exp_q.size() != DEPTH) && !flush;
    m_pop  = out_ready && (exp_q.size() != 0) && !flush;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(in_data);
    end
  endtask

  task automatic cycle(input logic f, input logic iv, input logic [DW-1:0] d, input logic ordy);
    drive(f, iv, d, ordy);
    #2;
    check_model();
    @(posedge clk);
    update_model();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (exp_q.size() == 0) break;
      cycle(1'b0, 1'b0, '0, 1'b1);
    end
    check("drain_empty", DW'(exp_q.size()), '0);
  endtask

  initial begin
    int seen;

    // Reset/idle, single word, then fill-to-full and drain (DEPTH=4, AF=3)
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         3'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 32'h0,         3'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 3'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         3'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h10,        1'b0, 1'b1, 1'b0, 32'h0,         3'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h11,        1'b0, 1'b1, 1'b1, 32'h10,        3'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h12,        1'b0, 1'b1, 1'b1, 32'h10,        3'd2, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h13,        1'b0, 1'b1, 1'b1, 32'h10,        3'd3, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'h14,        1'b0, 1'b0, 1'b1, 32'h10,        3'd4, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h15,        1'b0, 1'b0, 1'b1, 32'h10,        3'd4, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h10,        3'd4, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h11,        3'd3, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h12,        3'd2, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h13,        3'd1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         3'd0, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_count", DW'(count), '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      #2;
      check($sformatf("vec%0d_in_ready", i), DW'(in_ready), DW'(vecs[i].ir));
      check($sformatf("vec%0d_out_valid", i), DW'(out_valid), DW'(vecs[i].ov));
      if (vecs[i].ov) check($sformatf("vec%0d_out_data", i), out_data, vecs[i].od);
      check($sformatf("vec%0d_count", i), DW'(count), DW'(vecs[i].cnt));
      check($sformatf("vec%0d_almost_full", i), DW'(almost_full), DW'(vecs[i].af));
      check_model();
      @(posedge clk);
      update_model();
    end

    // Streaming: one word per cycle with no bubbles after the first
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b1, DW'(32'h1000 + i), 1'b1);
      if (out_valid) seen++;
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    if (out_valid) seen++;
    check("stream_words", DW'(seen), DW'(100));
    drain();

    // count=2 then simultaneous push+pop
    cycle(1'b0, 1'b1, 32'h2000, 1'b0);
    cycle(1'b0, 1'b1, 32'h2001, 1'b0);
    cycle(1'b0, 1'b1, 32'h2002, 1'b1);
    #3;
    check("pushpop_count", DW'(count), DW'(2));
    check("pushpop_head", out_data, 32'h2001);
    drain();

    // Randomised traffic with rare flushes
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    drain();

    // Flush at count=3 with both sides willing
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, DW'(32'h3000 + i), 1'b0);
    cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    cycle(1'b0, 1'b1, 32'hF00D, 1'b0);
    #3;
    check("post_flush_head", out_data, 32'hF00D);
    check("post_flush_count", DW'(count), DW'(1));
    drain();

    // Asynchronous reset mid-cycle at count=3
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, DW'(32'h4000 + i), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", DW'(out_valid), '0);
    check("arst_count", DW'(count), '0);
    check("arst_in_ready", DW'(in_ready), DW'(1));
    check("arst_almost_full", DW'(almost_full), '0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, DW'(32'h5000 + i), 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_buffer.md
Name: elastic_buffer

Overview:
Parametrised valid/ready elastic stage. It is the successor to the team's single-entry pipeline register, generalised to DEPTH entries. It fully decouples in_ready from out_ready, so there is no combinational backpressure path, and it adds synchronous flush, an occupancy count and an almost_full flag. It is inserted between datapath stages on long or timing-critical paths and at clock-region boundaries, same clock only.

Parameters:
DATA_WIDTH, 32, payload width in bits.
DEPTH, 4, number of storage entries; power of 2, ≥2. DEPTH<2 is an elaboration error.
AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
CW, $clog2(DEPTH+1), derived width of count; not to be overridden.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous discard of all stored entries
in_valid  in  1  upstream has data
in_ready  out  1  buffer can accept this cycle
in_data  in  DATA_WIDTH  upstream payload
out_valid  out  1  buffer holds data for downstream
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH  head-of-queue payload
count  out  CW  current occupancy, 0..DEPTH
almost_full  out  1  count ≥ AF_THRESH

Behaviour:
- Storage: DEPTH-entry circular buffer with wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap) and an occupancy counter. Strict FIFO order. Storage array is not reset.
- Reset (async assert, sync release via clk): wr_ptr=rd_ptr=0, count=0. Outputs: out_valid=0, almost_full=0, in_ready=1 (flush low). out_data is don't-care.
- Reset mid-operation discards all contents; no partial transfer completes.
- in_ready = (count != DEPTH) && !flush. It depends only on registered state and flush, never on out_ready or in_valid.
- out_valid = (count != 0) && !flush.
- out_data = mem[rd_ptr], driven from registered storage.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- push writes in_data at wr_ptr, then wr_ptr+1. pop advances rd_ptr.
- count update: push only → +1; pop only → −1; both → unchanged; neither → unchanged.
- Latency: a word accepted at edge N is presented on out_data/out_valid after edge N (visible cycle N+1). There is no same-cycle bypass.
- Throughput: with DEPTH ≥ 2, sustains one word per cycle indefinitely when out_ready is held high.
- Full (count==DEPTH): in_ready=0 even if out_ready=1 that cycle. The pop completes, and in_ready returns to 1 the following cycle.
- Empty (count==0): out_valid=0. A push that cycle makes out_valid=1 next cycle.
- Stall: while out_valid && !out_ready, out_data and out_valid are held stable. The AXI-style rule applies: once asserted, out_valid is not withdrawn except by flush or reset.
- Flush: while flush=1, in_ready=0 and out_valid=0 combinationally, so no push or pop occurs. At that edge wr_ptr=rd_ptr=count=0.
  - flush has priority over every other event.
  - Flush with the buffer empty is a no-op.
- almost_full = (count ≥ AF_THRESH), decoded from the registered count.
- Upstream is expected to hold in_data stable while in_valid && !in_ready; the buffer does not depend on this.

Test Plan:
1. Reset then idle; DEPTH=4 → in_ready=1, out_valid=0, count=0, almost_full=0. Push 0xA5A5_0001 at edge 0 with out_ready=1 → out_valid=1, out_data=0xA5A5_0001 in cycle 1, popped at edge 1, count back to 0.
2. out_ready=0, push 0x10..0x15 back-to-back → 0x10..0x13 accepted. in_ready=0 from cycle 4, count=4, almost_full=1 from count=3. Then raise out_ready → drain order 0x10,0x11,0x12,0x13, one per cycle; in_ready=1 the cycle after the first pop.
3. Streaming: in_valid=out_ready=1 for 100 cycles with incrementing data → 100 words out in order, zero bubbles after first, count constant at 1.
4. count=2, simultaneous push+pop → count stays 2, head advances, new word lands at tail. Randomised in_valid/out_ready for 10k cycles vs reference queue model → no loss, duplication or reorder.
5. count=3, assert flush one cycle with in_valid=out_ready=1 → in_ready=out_valid=0 that cycle, no transfer, count=0 next cycle. Next push emerges as first output.
6. count=3, assert rst_n=0 asynchronously mid-cycle → out_valid=0, count=0 immediately. After release, a new stream is delivered with no stale data.
